// File: rtl/alu_lm_19101664.sv
`default_nettype none
// ============================================================================
//  Module   : alu_lm_19101664
//  Brief    : 32-bit MIPS-style ALU (AND/OR/ADD/SUB/SLT/NOR) with registered
//             result and zero flag; one clock of latency.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_lm_19101664 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             zeroFlag
);

    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;
    localparam logic [3:0] c_op_nor = 4'b1100;

    logic [WIDTH-1:0] w_result;
    logic             w_lt;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;

    // SLT uses a true signed compare so results stay correct when A - B overflows.
    assign w_lt = ($signed(A) < $signed(B));

    // Operation select; unknown codes produce zero so the flag reads as set.
    always_comb begin
        w_result = '0;
        case (op)
            c_op_and: w_result = A & B;
            c_op_or:  w_result = A | B;
            c_op_add: w_result = A + B;
            c_op_sub: w_result = A - B;
            c_op_slt: w_result = {{(WIDTH-1){1'b0}}, w_lt};
            c_op_nor: w_result = ~(A | B);
            default:  w_result = '0;
        endcase
    end

    // Output register; the zero flag is derived from the same next value so it
    // can never disagree with res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_res  <= w_result;
            r_zero <= (w_result == '0);
        end
    end

    assign res      = r_res;
    assign zeroFlag = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_lm_19101664.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_lm_19101664
//  Brief    : Self-checking bench for alu_lm_19101664: directed cases plus
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_lm_19101664;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zeroFlag;

    int n_tests;
    int n_fail;

    alu_lm_19101664 #(.WIDTH(32)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .op       (op),
        .res      (res),
        .zeroFlag (zeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU written straight from the operation table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
        int          sa;
        int          sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (o)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Drive operands on the falling edge, check one rising edge later.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] o, input logic [31:0] exp);
        @(negedge clk);
        A  = a;
        B  = b;
        op = o;
        @(posedge clk);
        #1;
        check({tag, ".res"}, res, exp);
        check({tag, ".zf"}, {31'd0, zeroFlag}, {31'd0, (exp == 32'd0)});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops [6];
        logic [31:0] corners [6];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  ro;

        n_tests = 0;
        n_fail  = 0;
        ops     = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

        // Reset held while clocking
        rst_n = 1'b0;
        A = 32'd5; B = 32'd7; op = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        check("rst.res", res, 32'd0);
        check("rst.zf", {31'd0, zeroFlag}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release.res", res, 32'd12);
        check("rst_release.zf", {31'd0, zeroFlag}, 32'd0);

        // Directed cases
        apply("and11",    32'd1,         32'd1,         4'd0,  32'd1);
        apply("or10",     32'd1,         32'd0,         4'd1,  32'd1);
        apply("nor",      32'd17,        32'd13,        4'd12, 32'hFFFF_FFE2);
        apply("add",      32'd3,         32'd2,         4'd2,  32'd5);
        apply("sub",      32'd15,        32'd10,        4'd6,  32'd5);
        apply("add_wrap", 32'hFFFF_FFFF, 32'd1,         4'd2,  32'd0);
        apply("sub_wrap", 32'd0,         32'd1,         4'd6,  32'hFFFF_FFFF);
        apply("slt_gt",   32'd10,        32'd5,         4'd7,  32'd0);
        apply("slt_lt",   32'd8,         32'd12,        4'd7,  32'd1);
        apply("slt_neg",  32'hFFFF_FFFF, 32'd1,         4'd7,  32'd1);
        apply("slt_min",  32'd1,         32'h8000_0000, 4'd7,  32'd0);
        apply("slt_ovf",  32'h8000_0000, 32'd1,         4'd7,  32'd1);
        apply("illegal3", 32'hFFFF,      32'hFFFF,      4'd3,  32'd0);

        // Every code once, including all undefined ones
        for (int i = 0; i < 16; i++)
            apply("allops", 32'hF0F0_1234, 32'h0FF0_8765, i[3:0],
                  model(32'hF0F0_1234, 32'h0FF0_8765, i[3:0]));

        // Back-to-back op changes across the six legal codes
        for (int i = 0; i < 12; i++)
            apply("b2b", 32'h1234_5678 + i, 32'h0000_9ABC * i, ops[i % 6],
                  model(32'h1234_5678 + i, 32'h0000_9ABC * i, ops[i % 6]));

        // Asynchronous reset mid-stream clears without a clock edge
        apply("pre_async", 32'd100, 32'd23, 4'd2, 32'd123);
        @(negedge clk);
        A = 32'd9; B = 32'd9; op = 4'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async.res", res, 32'd0);
        check("async.zf", {31'd0, zeroFlag}, 32'd1);
        @(posedge clk);
        #1;
        check("async_hold.res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_rel.res", res, 32'd9);

        // Randomized traffic with corner operands mixed in
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            ro = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
            apply("rand", ra, rb, ro, model(ra, rb, ro));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_lm_19101664.md
Name: alu_lm_19101664

Overview:
- 32-bit MIPS-style ALU for the single-cycle datapath; computes AND/OR/ADD/SUB/SLT/NOR selected by a 4-bit ALU-control code.
- Result and zero flag are registered: one clock of latency from operand/op change to output.
- Sits between the register file / immediate mux (A, B) and the data-memory address / branch-compare logic (res, zeroFlag).

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is required to be supported by the test plan.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt or immediate)
- op  input  4  ALU control code
- res  output  WIDTH  registered result
- zeroFlag  output  1  registered; 1 when res is all zeros

Behaviour:
- Reset:
  - rst_n low asynchronously forces res = 0 and zeroFlag = 1, without waiting for clk.
  - Outputs hold those values while rst_n is low.
  - First capture occurs on the first rising clk edge after rst_n goes high.
- Capture: on every rising clk edge with rst_n high, res <= f(A, B, op), with A, B and op sampled at that edge. Latency is exactly 1 cycle. No enable; the block captures every cycle.
- zeroFlag <= (next res == 0). It is updated in the same edge as res, so it is always consistent with res.
- Op encoding (op[3:0]):
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^32; carry and overflow discarded
  - 0110 SUB: A - B, modulo 2^32; borrow and overflow discarded
  - 0111 SLT: 1 if A < B as signed two's complement, else 0; upper 31 bits are 0
  - 1100 NOR: ~(A | B)
  - Any other code: res = 0, zeroFlag = 1
- SLT must be correct across sign boundaries, e.g. A = 0xFFFFFFFF (-1), B = 1 gives 1. Compute it from a true signed compare, not from the sign of a truncated subtraction.
- Purely datapath: no FSM, no handshake. Inputs may change every cycle.
- If reset is asserted mid-stream, any pending result is discarded; outputs go to the reset values immediately.

Test Plan:
- Reset: hold rst_n = 0 with A = 5, B = 7, op = 2 and toggle clk -> res = 0, zeroFlag = 1. Deassert rst_n -> next edge gives res = 12.
- Logic ops, each checked one edge after applying stimulus:
  - A = 1, B = 1, op = 0 -> res = 1, zeroFlag = 0
  - A = 1, B = 0, op = 1 -> res = 1
  - A = 17, B = 13, op = 12 -> res = 0xFFFFFFE2
- Arithmetic:
  - A = 3, B = 2, op = 2 -> res = 5
  - A = 15, B = 10, op = 6 -> res = 5
  - A = 0xFFFFFFFF, B = 1, op = 2 -> res = 0, zeroFlag = 1 (wrap)
  - A = 0, B = 1, op = 6 -> res = 0xFFFFFFFF
- SLT:
  - A = 10, B = 5, op = 7 -> res = 0, zeroFlag = 1
  - A = 8, B = 12, op = 7 -> res = 1, zeroFlag = 0
  - A = 0xFFFFFFFF, B = 1, op = 7 -> res = 1
  - A = 1, B = 0x80000000, op = 7 -> res = 0
- Illegal op: op = 3, A = B = 0xFFFF -> res = 0, zeroFlag = 1.
- Back-to-back: change op every cycle across all six codes -> each result appears exactly one edge later. Assert rst_n low between edges -> outputs clear immediately.
